// File: rtl/sap_pkg.sv
// sap_pkg: definitions shared by the fetch stage and the control unit decoder.
//   fetch_state_t : fetch FSM state encoding
//   LEN2_BIT      : opcode bit that marks a 2-byte (opcode + operand) instruction
package sap_pkg;

    typedef enum logic [2:0] {
        ST_SETTLE = 3'd0,  // wait for PC_VAL to settle after a PC update
        ST_RD     = 3'd1,  // memory read handshake in flight
        ST_INC    = 3'd2,  // request PC increment, wait for a step strobe
        ST_OUT    = 3'd3,  // instruction presented to the control unit
        ST_ERR    = 3'd4   // memory timeout, only reset leaves
    } fetch_state_t;

    localparam int LEN2_BIT = 7;

endpackage

// File: rtl/fetch_timer.sv
// fetch_timer: loadable down-counter shared by the settle delay and the read
// timeout. Load has priority over decrement; decrement saturates at zero.
//   CLK, RST  : clock, synchronous active-high reset (counter -> RST_VAL)
//   load      : load load_val this cycle
//   load_val  : value to load
//   dec       : decrement by one (ignored when zero or when loading)
//   zero      : counter currently holds zero
module fetch_timer #(
    parameter int                CNT_W   = 4,
    parameter logic [CNT_W-1:0]  RST_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage between the program counter and the control unit.
// Reads 1- or 2-byte instructions from program memory, advances the PC once per
// byte and presents the instruction on a valid/ready handshake.
//   CLK, RST         : clock, synchronous active-high reset
//   SLOW_CLOCK_STRB  : CPU step strobe; the PC only honours PC_COUNT when high
//   PC_VAL           : current PC;  PC_COUNT : increment request
//   FLUSH            : branch taken, abort and refetch from the new PC
//   MEM_ADDR/MEM_RD  : read request;  MEM_DATA/MEM_VALID : read response
//   INSTR_*          : instruction handshake and payload to the control unit
//   FETCH_ERR        : sticky memory-timeout flag
module instruction_fetch
    import sap_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int PC_SETTLE   = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SLOW_CLOCK_STRB,
    input  logic [ADDR_W-1:0] PC_VAL,
    output logic              PC_COUNT,
    input  logic              FLUSH,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_RD,
    input  logic [DATA_W-1:0] MEM_DATA,
    input  logic              MEM_VALID,
    output logic              INSTR_VALID,
    input  logic              INSTR_READY,
    output logic [DATA_W-1:0] INSTR_OPCODE,
    output logic [DATA_W-1:0] INSTR_OPERAND,
    output logic              INSTR_LEN2,
    output logic              FETCH_ERR
);

    // One counter covers both delays, so size it for the larger one.
    localparam int TMR_MAX = (PC_SETTLE > MEM_TIMEOUT) ? PC_SETTLE - 1 : MEM_TIMEOUT - 1;
    localparam int CNT_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(PC_SETTLE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(MEM_TIMEOUT - 1);

    fetch_state_t      state_q, state_d;
    logic              byte_sel_q, byte_sel_d;
    logic [DATA_W-1:0] opcode_q, operand_q;
    logic              latch_opcode, latch_operand;
    logic              tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0]  tmr_load_val;

    fetch_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (SETTLE_LOAD)
    ) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_SETTLE;
            byte_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_sel_q <= byte_sel_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        byte_sel_d    = byte_sel_q;
        latch_opcode  = 1'b0;
        latch_operand = 1'b0;
        tmr_load      = 1'b0;
        tmr_load_val  = SETTLE_LOAD;
        tmr_dec       = 1'b0;

        case (state_q)
            ST_SETTLE: begin
                tmr_dec = 1'b1;
                if (tmr_zero) begin
                    state_d      = ST_RD;
                    tmr_load     = 1'b1;
                    tmr_load_val = TIMEOUT_LOAD;
                end
            end
            ST_RD: begin
                if (MEM_VALID) begin
                    latch_opcode  = !byte_sel_q;
                    latch_operand = byte_sel_q;
                    state_d       = ST_INC;
                end else if (tmr_zero) begin
                    state_d = ST_ERR;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_INC: begin
                if (SLOW_CLOCK_STRB) begin
                    if (!byte_sel_q && opcode_q[LEN2_BIT]) begin
                        byte_sel_d = 1'b1;
                        state_d    = ST_SETTLE;
                        tmr_load   = 1'b1;
                    end else begin
                        state_d = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                if (INSTR_READY) begin
                    byte_sel_d = 1'b0;
                    state_d    = ST_SETTLE;
                    tmr_load   = 1'b1;
                end
            end
            default: state_d = ST_ERR;
        endcase

        // Flush overrides everything except the error trap. An OUT accept in the
        // same cycle has already been seen by the consumer (VALID & READY), and
        // both paths land in the same restart state.
        if (FLUSH && (state_q != ST_ERR)) begin
            state_d       = ST_SETTLE;
            byte_sel_d    = 1'b0;
            tmr_load      = 1'b1;
            tmr_load_val  = SETTLE_LOAD;
            latch_opcode  = 1'b0;
            latch_operand = 1'b0;
        end
    end

    // Operand is cleared with every opcode latch so 1-byte instructions show 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            opcode_q  <= '0;
            operand_q <= '0;
        end else if (latch_opcode) begin
            opcode_q  <= MEM_DATA;
            operand_q <= '0;
        end else if (latch_operand) begin
            operand_q <= MEM_DATA;
        end
    end

    assign MEM_RD        = (state_q == ST_RD);
    assign MEM_ADDR      = MEM_RD ? PC_VAL : '0;
    assign PC_COUNT      = (state_q == ST_INC);
    assign INSTR_VALID   = (state_q == ST_OUT);
    assign INSTR_OPCODE  = INSTR_VALID ? opcode_q  : '0;
    assign INSTR_OPERAND = INSTR_VALID ? operand_q : '0;
    assign INSTR_LEN2    = INSTR_VALID & opcode_q[LEN2_BIT];
    assign FETCH_ERR     = (state_q == ST_ERR);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural PC and program memory.
module tb_instruction_fetch;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       SLOW_CLOCK_STRB;
    logic [7:0] PC_VAL;
    logic       PC_COUNT;
    logic       FLUSH = 1'b0;
    logic [7:0] MEM_ADDR;
    logic       MEM_RD;
    logic [7:0] MEM_DATA;
    logic       MEM_VALID;
    logic       INSTR_VALID;
    logic       INSTR_READY = 1'b0;
    logic [7:0] INSTR_OPCODE;
    logic [7:0] INSTR_OPERAND;
    logic       INSTR_LEN2;
    logic       FETCH_ERR;

    int checks = 0;
    int errors = 0;

    // environment model
    logic [7:0] mem [256];
    logic       strobe_all = 1'b1;
    logic [1:0] div;
    logic       auto_resp = 1'b1;
    logic       man_valid = 1'b0;
    logic [7:0] man_data  = 8'h00;
    logic [7:0] pc;
    logic       pc_load = 1'b0;
    logic [7:0] pc_load_val = 8'h00;
    int         inc_cnt;
    int         acc_cnt;

    assign SLOW_CLOCK_STRB = strobe_all ? 1'b1 : (div == 2'd0);
    assign PC_VAL          = pc;
    assign MEM_VALID       = auto_resp ? MEM_RD : man_valid;
    assign MEM_DATA        = auto_resp ? mem[MEM_ADDR] : man_data;

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (RST) begin
            pc      <= 8'h00;
            div     <= 2'd0;
            inc_cnt <= 0;
            acc_cnt <= 0;
        end else begin
            div <= div + 2'd1;
            if (pc_load)
                pc <= pc_load_val;
            else if (PC_COUNT && SLOW_CLOCK_STRB)
                pc <= pc + 8'h01;
            if (PC_COUNT && SLOW_CLOCK_STRB)
                inc_cnt <= inc_cnt + 1;
            if (INSTR_VALID && INSTR_READY)
                acc_cnt <= acc_cnt + 1;
        end
    end

    instruction_fetch #(
        .ADDR_W(8), .DATA_W(8), .PC_SETTLE(2), .MEM_TIMEOUT(15)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .SLOW_CLOCK_STRB (SLOW_CLOCK_STRB),
        .PC_VAL          (PC_VAL),
        .PC_COUNT        (PC_COUNT),
        .FLUSH           (FLUSH),
        .MEM_ADDR        (MEM_ADDR),
        .MEM_RD          (MEM_RD),
        .MEM_DATA        (MEM_DATA),
        .MEM_VALID       (MEM_VALID),
        .INSTR_VALID     (INSTR_VALID),
        .INSTR_READY     (INSTR_READY),
        .INSTR_OPCODE    (INSTR_OPCODE),
        .INSTR_OPERAND   (INSTR_OPERAND),
        .INSTR_LEN2      (INSTR_LEN2),
        .FETCH_ERR       (FETCH_ERR)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Leaves RST low at a negedge: the next rising edge is edge 1.
    task automatic do_reset();
        RST = 1'b1; FLUSH = 1'b0; INSTR_READY = 1'b0; pc_load = 1'b0;
        man_valid = 1'b0; man_data = 8'h00;
        tick(2);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick(2);
        checks++; if ({INSTR_VALID, MEM_RD, PC_COUNT, FETCH_ERR, INSTR_LEN2} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b exp 00000", {INSTR_VALID, MEM_RD, PC_COUNT, FETCH_ERR, INSTR_LEN2});
        end
        checks++; if ({MEM_ADDR, INSTR_OPCODE, INSTR_OPERAND} !== 24'h0) begin
            errors++; $display("FAIL reset_data: got %h exp 000000", {MEM_ADDR, INSTR_OPCODE, INSTR_OPERAND});
        end
    endtask

    task automatic test_one_byte();
        strobe_all = 1'b1; auto_resp = 1'b1;
        mem[0] = 8'h12; mem[1] = 8'h21;
        do_reset();
        tick(1);
        checks++; if (MEM_RD !== 1'b0) begin errors++; $display("FAIL 1b_settle_e1: MEM_RD got %b exp 0", MEM_RD); end
        tick(1);
        checks++; if ({MEM_RD, MEM_ADDR} !== {1'b1, 8'h00}) begin
            errors++; $display("FAIL 1b_rd_e2: got %b/%h exp 1/00", MEM_RD, MEM_ADDR);
        end
        tick(1);
        checks++; if ({PC_COUNT, INSTR_VALID} !== 2'b10) begin
            errors++; $display("FAIL 1b_inc_e3: pc_count/valid got %b exp 10", {PC_COUNT, INSTR_VALID});
        end
        tick(1);
        checks++; if ({INSTR_VALID, INSTR_OPCODE, INSTR_OPERAND, INSTR_LEN2} !== {1'b1, 8'h12, 8'h00, 1'b0}) begin
            errors++; $display("FAIL 1b_out_e4: got %b %h %h %b exp 1 12 00 0", INSTR_VALID, INSTR_OPCODE, INSTR_OPERAND, INSTR_LEN2);
        end
        checks++; if (pc !== 8'h01) begin errors++; $display("FAIL 1b_pc: got %h exp 01", pc); end
        INSTR_READY = 1'b1;
        tick(1);
        INSTR_READY = 1'b0;
        checks++; if (INSTR_VALID !== 1'b0) begin errors++; $display("FAIL 1b_accept_drop: got %b exp 0", INSTR_VALID); end
        tick(3);
        checks++; if (INSTR_VALID !== 1'b0) begin errors++; $display("FAIL 1b_next_early: got %b exp 0", INSTR_VALID); end
        tick(1);
        checks++; if ({INSTR_VALID, INSTR_OPCODE} !== {1'b1, 8'h21}) begin
            errors++; $display("FAIL 1b_next_valid: got %b %h exp 1 21", INSTR_VALID, INSTR_OPCODE);
        end
    endtask

    task automatic test_two_byte();
        strobe_all = 1'b1; auto_resp = 1'b1;
        mem[0] = 8'h85; mem[1] = 8'h3C;
        do_reset();
        tick(7);
        checks++; if (INSTR_VALID !== 1'b0) begin errors++; $display("FAIL 2b_early_e7: got %b exp 0", INSTR_VALID); end
        tick(1);
        checks++; if ({INSTR_VALID, INSTR_OPCODE, INSTR_OPERAND, INSTR_LEN2} !== {1'b1, 8'h85, 8'h3C, 1'b1}) begin
            errors++; $display("FAIL 2b_out_e8: got %b %h %h %b exp 1 85 3c 1", INSTR_VALID, INSTR_OPCODE, INSTR_OPERAND, INSTR_LEN2);
        end
        checks++; if (inc_cnt !== 2) begin errors++; $display("FAIL 2b_inc_count: got %0d exp 2", inc_cnt); end
        checks++; if (pc !== 8'h02) begin errors++; $display("FAIL 2b_pc: got %h exp 02", pc); end
    endtask

    // Strobe high only in windows after edges 4, 8, ...
    task automatic test_slow_strobe();
        strobe_all = 1'b0; auto_resp = 1'b1;
        mem[0] = 8'h85; mem[1] = 8'h3C;
        do_reset();
        tick(3);
        checks++; if ({PC_COUNT, SLOW_CLOCK_STRB} !== 2'b10) begin
            errors++; $display("FAIL strb_wait_e3: pc_count/strb got %b exp 10", {PC_COUNT, SLOW_CLOCK_STRB});
        end
        tick(1);
        checks++; if ({PC_COUNT, SLOW_CLOCK_STRB, inc_cnt[1:0]} !== 4'b1100) begin
            errors++; $display("FAIL strb_held_e4: got %b/%0d exp 11/0", {PC_COUNT, SLOW_CLOCK_STRB}, inc_cnt);
        end
        tick(1);
        checks++; if ({PC_COUNT, inc_cnt[1:0], pc} !== {1'b0, 2'd1, 8'h01}) begin
            errors++; $display("FAIL strb_drop_e5: pc_count %b inc %0d pc %h exp 0 1 01", PC_COUNT, inc_cnt, pc);
        end
        tick(3);
        checks++; if ({PC_COUNT, inc_cnt[1:0]} !== {1'b1, 2'd1}) begin
            errors++; $display("FAIL strb_op_e8: pc_count %b inc %0d exp 1 1", PC_COUNT, inc_cnt);
        end
        tick(1);
        checks++; if ({INSTR_VALID, INSTR_OPERAND, PC_COUNT} !== {1'b1, 8'h3C, 1'b0}) begin
            errors++; $display("FAIL strb_out_e9: got %b %h %b exp 1 3c 0", INSTR_VALID, INSTR_OPERAND, PC_COUNT);
        end
        checks++; if ({inc_cnt[1:0], pc} !== {2'd2, 8'h02}) begin
            errors++; $display("FAIL strb_incs: inc %0d pc %h exp 2 02", inc_cnt, pc);
        end
    endtask

    task automatic test_flush();
        strobe_all = 1'b1; auto_resp = 1'b0;
        mem[8'h40] = 8'h07;
        do_reset();
        tick(2);
        checks++; if (MEM_RD !== 1'b1) begin errors++; $display("FAIL fl_rd_e2: got %b exp 1", MEM_RD); end
        FLUSH = 1'b1; pc_load = 1'b1; pc_load_val = 8'h40;
        tick(1);
        FLUSH = 1'b0; pc_load = 1'b0; man_valid = 1'b1; man_data = 8'hEE;
        checks++; if ({MEM_RD, pc} !== {1'b0, 8'h40}) begin
            errors++; $display("FAIL fl_abort_e3: rd %b pc %h exp 0 40", MEM_RD, pc);
        end
        tick(1);
        man_valid = 1'b0;
        checks++; if ({MEM_RD, PC_COUNT, INSTR_VALID} !== 3'b000) begin
            errors++; $display("FAIL fl_late_ignored_e4: got %b exp 000", {MEM_RD, PC_COUNT, INSTR_VALID});
        end
        tick(1);
        checks++; if ({MEM_RD, MEM_ADDR} !== {1'b1, 8'h40}) begin
            errors++; $display("FAIL fl_reissue_e5: got %b/%h exp 1/40", MEM_RD, MEM_ADDR);
        end
        auto_resp = 1'b1;
        tick(2);
        checks++; if ({INSTR_VALID, INSTR_OPCODE, INSTR_OPERAND} !== {1'b1, 8'h07, 8'h00}) begin
            errors++; $display("FAIL fl_refetch_e7: got %b %h %h exp 1 07 00", INSTR_VALID, INSTR_OPCODE, INSTR_OPERAND);
        end
    endtask

    task automatic test_hold_and_flush_accept();
        strobe_all = 1'b1; auto_resp = 1'b1;
        mem[0] = 8'h85; mem[1] = 8'h3C; mem[8'h50] = 8'h22;
        do_reset();
        tick(8);
        for (int i = 0; i < 10; i++) begin
            checks++; if ({INSTR_VALID, INSTR_OPCODE, INSTR_OPERAND, INSTR_LEN2} !== {1'b1, 8'h85, 8'h3C, 1'b1}) begin
                errors++; $display("FAIL hold_%0d: got %b %h %h %b exp 1 85 3c 1", i, INSTR_VALID, INSTR_OPCODE, INSTR_OPERAND, INSTR_LEN2);
            end
            tick(1);
        end
        INSTR_READY = 1'b1; FLUSH = 1'b1; pc_load = 1'b1; pc_load_val = 8'h50;
        tick(1);
        INSTR_READY = 1'b0; FLUSH = 1'b0; pc_load = 1'b0;
        checks++; if ({INSTR_VALID, acc_cnt[3:0], pc} !== {1'b0, 4'd1, 8'h50}) begin
            errors++; $display("FAIL flush_accept: valid %b acc %0d pc %h exp 0 1 50", INSTR_VALID, acc_cnt, pc);
        end
        tick(3);
        checks++; if (INSTR_VALID !== 1'b0) begin errors++; $display("FAIL flush_accept_early: got %b exp 0", INSTR_VALID); end
        tick(1);
        checks++; if ({INSTR_VALID, INSTR_OPCODE, INSTR_LEN2, acc_cnt[3:0]} !== {1'b1, 8'h22, 1'b0, 4'd1}) begin
            errors++; $display("FAIL flush_accept_next: got %b %h %b acc %0d exp 1 22 0 1", INSTR_VALID, INSTR_OPCODE, INSTR_LEN2, acc_cnt);
        end
    endtask

    task automatic test_timeout();
        strobe_all = 1'b1; auto_resp = 1'b0;
        do_reset();
        tick(16);
        checks++; if ({MEM_RD, FETCH_ERR} !== 2'b10) begin
            errors++; $display("FAIL to_last_rd_e16: got %b exp 10", {MEM_RD, FETCH_ERR});
        end
        tick(1);
        checks++; if ({MEM_RD, FETCH_ERR, INSTR_VALID, PC_COUNT, MEM_ADDR} !== {4'b0100, 8'h00}) begin
            errors++; $display("FAIL to_err_e17: got %b/%h exp 0100/00", {MEM_RD, FETCH_ERR, INSTR_VALID, PC_COUNT}, MEM_ADDR);
        end
        FLUSH = 1'b1; man_valid = 1'b1; INSTR_READY = 1'b1;
        tick(3);
        FLUSH = 1'b0; man_valid = 1'b0; INSTR_READY = 1'b0;
        checks++; if ({FETCH_ERR, MEM_RD, INSTR_VALID} !== 3'b100) begin
            errors++; $display("FAIL to_sticky: got %b exp 100", {FETCH_ERR, MEM_RD, INSTR_VALID});
        end
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        checks++; if (FETCH_ERR !== 1'b0) begin errors++; $display("FAIL to_rst_clear: got %b exp 0", FETCH_ERR); end
    endtask

    task automatic test_reset_mid_handshake();
        strobe_all = 1'b1; auto_resp = 1'b1;
        mem[0] = 8'h12;
        do_reset();
        tick(4);
        RST = 1'b1; INSTR_READY = 1'b1;
        tick(1);
        checks++; if ({INSTR_VALID, INSTR_OPCODE} !== {1'b0, 8'h00}) begin
            errors++; $display("FAIL rst_mid: got %b %h exp 0 00", INSTR_VALID, INSTR_OPCODE);
        end
        RST = 1'b0; INSTR_READY = 1'b0;
        tick(1);
        checks++; if ({MEM_RD, INSTR_VALID} !== 2'b00) begin
            errors++; $display("FAIL rst_mid_settle: got %b exp 00", {MEM_RD, INSTR_VALID});
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        test_reset();
        test_one_byte();
        test_two_byte();
        test_slow_strobe();
        test_flush();
        test_hold_and_flush_accept();
        test_timeout();
        test_reset_mid_handshake();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
